// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, state and datapath-select encodings for the multicycle MIPS control
//
// Purpose:
//   Single source of truth for the instruction opcodes recognised by the
//   multicycle sequencer, the sequencer state encoding, and the encodings of
//   the ALU source-B, next-PC and ALU-operation selects it drives.
//
// Contents:
//   OP_*        6-bit opcode constants
//   state_t     4-bit sequencer state encoding
//   alusrcb_t   ALU source B select
//   pcsrc_t     next-PC select
//   aluop_t     ALU operation class handed to the ALU decoder
//   decode_next maps an opcode to the state that follows DECODE
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_RTEXEC = 4'd6,
        ST_RTWB   = 4'd7,
        ST_BEQ    = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JMP    = 4'd11,
        ST_TRAP   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Dispatch from DECODE; anything not in the supported set traps.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:     nxt = ST_RTEXEC;
            OP_LW, OP_SW: nxt = ST_MEMADR;
            OP_BEQ:       nxt = ST_BEQ;
            OP_ADDI:      nxt = ST_ADDIEX;
            OP_J:         nxt = ST_JMP;
            default:      nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control sequencer for the shared-memory MIPS datapath
//
// Purpose:
//   Steps each instruction through fetch, decode, address/execute, memory and
//   writeback, driving the datapath selects and write enables for each step
//   and stalling on the memory ready handshake. ALU function decode remains
//   in the separate ALU decoder, which receives aluop from here.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   op[5:0]    in   opcode field of the instruction register
//   zero       in   ALU zero flag (same cycle)
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access active
//   memwrite   out  data memory write
//   iord       out  memory address select (0 PC, 1 ALUOut)
//   irwrite    out  instruction register load
//   pcen       out  PC load enable (pcwrite | branch & zero)
//   regdst     out  register write address (1 rd, 0 rt)
//   memtoreg   out  register write data (1 data register, 0 ALUOut)
//   regwrite   out  register file write enable
//   alusrca    out  ALU source A (0 PC, 1 register A)
//   alusrcb    out  ALU source B select
//   pcsrc      out  next-PC select
//   aluop      out  ALU operation class
//   illegal_op out  sticky: an unsupported opcode was decoded
module mc_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op
);

    state_t state_q, state_d;
    logic   illegal_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Set on entry to TRAP so the flag is visible from the first TRAP cycle.
            if (state_q == ST_DECODE && state_d == ST_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign illegal_op = illegal_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = decode_next(op);
            ST_MEMADR: state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_RTEXEC: state_d = ST_RTWB;
            ST_RTWB:   state_d = ST_FETCH;
            ST_BEQ:    state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            ST_JMP:    state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic     pcwrite;
    logic     branch;
    alusrcb_t srcb;
    pcsrc_t   pcs;
    aluop_t   aop;

    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        srcb     = SRCB_REGB;
        pcs      = PCSRC_ALU;
        aop      = ALUOP_ADD;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                srcb    = SRCB_FOUR;
                // PC+4 and the IR load commit only once the fetch returns.
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            ST_DECODE: begin
                srcb = SRCB_IMM_SH2;
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                srcb    = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            ST_RTEXEC: begin
                alusrca = 1'b1;
                srcb    = SRCB_REGB;
                aop     = ALUOP_FUNCT;
            end
            ST_RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ST_BEQ: begin
                alusrca = 1'b1;
                srcb    = SRCB_REGB;
                aop     = ALUOP_SUB;
                branch  = 1'b1;
                pcs     = PCSRC_ALUOUT;
            end
            ST_ADDIEX: begin
                alusrca = 1'b1;
                srcb    = SRCB_IMM;
            end
            ST_ADDIWB: begin
                regwrite = 1'b1;
            end
            ST_JMP: begin
                pcs     = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: begin
            end
        endcase

        pcen = pcwrite | (branch & zero);

        // Reset kills every write path in the same cycle so an aborted
        // instruction can never leave a partial update behind.
        if (reset) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign alusrcb = srcb;
    assign pcsrc   = pcs;
    assign aluop   = aop;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm against an instruction-level model
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal_op;

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction steps as seen by the programmer's model
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_RTEXEC = 6, S_RTWB = 7, S_BEQ = 8, S_ADDIEX = 9,
                   S_ADDIWB = 10, S_JMP = 11, S_TRAP = 12, S_RESET = 13;

    localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                           C_BEQ = 6'b000100, C_ADDI = 6'b001000, C_J = 6'b000010;

    // Bits: mem_req memwrite iord irwrite pcen regdst memtoreg regwrite alusrca
    //       alusrcb[1:0] pcsrc[1:0] aluop[1:0] illegal_op
    localparam logic [15:0] RESET_MASK = 16'hD901;

    typedef struct {
        logic [15:0] val;
        logic [15:0] mask;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic ill_state = 1'b0;

    function automatic string sname(int s);
        case (s)
            S_FETCH:  return "FETCH";
            S_DECODE: return "DECODE";
            S_MEMADR: return "MEMADR";
            S_MEMRD:  return "MEMRD";
            S_MEMWB:  return "MEMWB";
            S_MEMWR:  return "MEMWR";
            S_RTEXEC: return "RTEXEC";
            S_RTWB:   return "RTWB";
            S_BEQ:    return "BEQ";
            S_ADDIEX: return "ADDIEX";
            S_ADDIWB: return "ADDIWB";
            S_JMP:    return "JMP";
            S_TRAP:   return "TRAP";
            default:  return "RESET";
        endcase
    endfunction

    // Control word each step must present, from the step's role in the instruction.
    function automatic logic [15:0] model(int step, logic mr, logic z, logic ill);
        logic       mreq = 0, mw = 0, io = 0, irw = 0, pce = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
        logic [1:0] asb = 2'b00, pcs = 2'b00, aop = 2'b00;
        case (step)
            S_FETCH:  begin mreq = 1; asb = 2'b01; irw = mr; pce = mr; end
            S_DECODE: begin asb = 2'b11; end
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mreq = 1; io = 1; end
            S_MEMWB:  begin m2r = 1; rw = 1; end
            S_MEMWR:  begin mreq = 1; io = 1; mw = 1; end
            S_RTEXEC: begin asa = 1; aop = 2'b10; end
            S_RTWB:   begin rd = 1; rw = 1; end
            S_BEQ:    begin asa = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
            S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_ADDIWB: begin rw = 1; end
            S_JMP:    begin pcs = 2'b10; pce = 1; end
            default:  begin end
        endcase
        return {mreq, mw, io, irw, pce, rd, m2r, rw, asa, asb, pcs, aop, ill};
    endfunction

    task automatic cycle(int step, logic [5:0] op_v, logic mr, logic z, logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        op        = op_v;
        mem_ready = mr;
        zero      = z;
        e.val  = model(step, mr, z, ill);
        e.mask = 16'hFFFF;
        e.step = step;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset     = 1'b1;
            op        = 6'($urandom);
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            e.val  = {15'd0, ill_state};
            e.mask = RESET_MASK;
            e.step = S_RESET;
            exp_q.push_back(e);
            ill_state = 1'b0;
        end
    endtask

    task automatic run_instr(logic [5:0] opc, int fstall, int mstall, logic zb);
        for (int i = 0; i < fstall; i++) cycle(S_FETCH, 6'($urandom), 1'b0, 1'($urandom), 1'b0);
        cycle(S_FETCH, 6'($urandom), 1'b1, 1'($urandom), 1'b0);
        cycle(S_DECODE, opc, 1'($urandom), 1'($urandom), 1'b0);
        case (opc)
            C_LW: begin
                cycle(S_MEMADR, opc, 1'($urandom), 1'($urandom), 1'b0);
                for (int i = 0; i < mstall; i++) cycle(S_MEMRD, opc, 1'b0, 1'($urandom), 1'b0);
                cycle(S_MEMRD, opc, 1'b1, 1'($urandom), 1'b0);
                cycle(S_MEMWB, opc, 1'($urandom), 1'($urandom), 1'b0);
            end
            C_SW: begin
                cycle(S_MEMADR, opc, 1'($urandom), 1'($urandom), 1'b0);
                for (int i = 0; i < mstall; i++) cycle(S_MEMWR, opc, 1'b0, 1'($urandom), 1'b0);
                cycle(S_MEMWR, opc, 1'b1, 1'($urandom), 1'b0);
            end
            C_R: begin
                cycle(S_RTEXEC, opc, 1'($urandom), 1'($urandom), 1'b0);
                cycle(S_RTWB, opc, 1'($urandom), 1'($urandom), 1'b0);
            end
            C_BEQ: cycle(S_BEQ, opc, 1'($urandom), zb, 1'b0);
            C_ADDI: begin
                cycle(S_ADDIEX, opc, 1'($urandom), 1'($urandom), 1'b0);
                cycle(S_ADDIWB, opc, 1'($urandom), 1'($urandom), 1'b0);
            end
            C_J: cycle(S_JMP, opc, 1'($urandom), 1'($urandom), 1'b0);
            default: begin
                ill_state = 1'b1;
                for (int i = 0; i < 10; i++) cycle(S_TRAP, opc, 1'($urandom), 1'($urandom), 1'b1);
            end
        endcase
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] act;
            mon_e = exp_q.pop_front();
            act = {mem_req, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, aluop, illegal_op};
            checks = checks + 1;
            if ((act & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
                errors = errors + 1;
                $display("FAIL step=%s t=%0t actual=%04h required=%04h mask=%04h",
                         sname(mon_e.step), $time, act, mon_e.val, mon_e.mask);
            end
        end
    end

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops = '{C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J};
        reset     = 1'b1;
        op        = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        do_reset(2);

        // Directed test-plan sequences
        run_instr(C_LW, 0, 0, 1'b0);
        run_instr(C_SW, 0, 2, 1'b0);
        run_instr(C_BEQ, 0, 0, 1'b1);
        run_instr(C_BEQ, 0, 0, 1'b0);
        run_instr(C_R, 0, 0, 1'b0);
        run_instr(C_ADDI, 0, 0, 1'b0);
        run_instr(C_J, 0, 0, 1'b0);
        run_instr(C_LW, 3, 0, 1'b0);

        // Randomised instruction stream with random stalls
        for (int n = 0; n < 60; n++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom));
        end

        // Illegal opcode, then recovery
        run_instr(6'b111111, 0, 0, 1'b0);
        do_reset(1);
        run_instr(C_ADDI, 1, 0, 1'b0);
        run_instr(6'b001101, 0, 0, 1'b0);
        do_reset(2);
        run_instr(C_R, 0, 0, 1'b0);

        // Reset while a load is waiting in MEMRD: no writeback, back to FETCH
        cycle(S_FETCH, 6'd0, 1'b1, 1'b0, 1'b0);
        cycle(S_DECODE, C_LW, 1'b0, 1'b0, 1'b0);
        cycle(S_MEMADR, C_LW, 1'b0, 1'b0, 1'b0);
        cycle(S_MEMRD, C_LW, 1'b0, 1'b0, 1'b0);
        do_reset(1);
        run_instr(C_SW, 0, 1, 1'b0);
        run_instr(C_BEQ, 2, 0, 1'b1);

        repeat (3) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
